// File: rtl/spi_xfer_seq_if.sv
// spi_xfer_seq port bundle: TX/RX word streams and spi_core register bus.
// master = sequencer side, slave = software FIFO users plus spi_core.
interface spi_xfer_seq_if;
   logic [31:0] tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic [31:0] rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic [7:0]  addr;
   logic        we;
   logic        re;
   logic [3:0]  be;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        intr_tx;
   logic        intr_rx;

   modport master (
      input  tx_data, tx_valid, rx_ready,
      output tx_ready, rx_data, rx_valid,
      output addr, we, re, be, wdata,
      input  rdata, intr_tx, intr_rx
   );

   modport slave (
      output tx_data, tx_valid, rx_ready,
      input  tx_ready, rx_data, rx_valid,
      input  addr, we, re, be, wdata,
      output rdata, intr_tx, intr_rx
   );
endinterface

// File: rtl/spi_xfer_seq.sv
// SPI transfer sequencer: queues TX/RX words and drives spi_core's
// register port one word at a time (DIV, SS, then TX/GO/wait/RX per word).
module spi_xfer_seq_fifo #(
   parameter int DEPTH = 8
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     push_i,
   input  logic [31:0]              data_i,
   input  logic                     pop_i,
   output logic [31:0]              data_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   level_o
);
   localparam int AW = $clog2(DEPTH);

   logic [31:0]   mem [DEPTH];
   logic [AW-1:0] wr_q, rd_q;
   logic [AW:0]   cnt_q;
   logic          push_ok, pop_ok;

   assign full_o  = (cnt_q == (AW+1)'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign push_ok = push_i & ~full_o;
   assign pop_ok  = pop_i & ~empty_o;
   assign data_o  = mem[rd_q];
   assign level_o = cnt_q;

   always_ff @(posedge clk_i) begin
      if (push_ok) mem[wr_q] <= data_i;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (push_ok) wr_q <= wr_q + AW'(1);
         if (pop_ok)  rd_q <= rd_q + AW'(1);
         unique case (1'b1)
            push_ok & ~pop_ok: cnt_q <= cnt_q + (AW+1)'(1);
            pop_ok & ~push_ok: cnt_q <= cnt_q - (AW+1)'(1);
            default:           cnt_q <= cnt_q;
         endcase
      end
   end
endmodule

module spi_xfer_seq #(
   parameter int TX_DEPTH = 8,
   parameter int RX_DEPTH = 8,
   parameter int WDOG_W   = 16
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic                        start_i,
   input  logic                        abort_i,
   input  logic [7:0]                  nwords_i,
   input  logic [15:0]                 divider_i,
   input  logic [3:0]                  ss_i,
   input  logic [7:0]                  mode_i,
   input  logic [6:0]                  char_len_i,
   output logic                        busy_o,
   output logic                        done_o,
   output logic                        err_o,
   output logic [$clog2(TX_DEPTH):0]   tx_level_o,
   output logic [$clog2(RX_DEPTH):0]   rx_level_o,
   spi_xfer_seq_if.master              sif
);
   typedef enum logic [3:0] {
      IDLE, WR_DIV, WR_SS, WAIT_TX, WR_TX,
      WR_GO, WAIT_END, RD_REQ, RD_CAP, FIN
   } state_e;

   state_e            state_q, state_d;
   logic [7:0]        rem_q;
   logic [15:0]       div_q;
   logic [3:0]        ss_q;
   logic [7:0]        mode_q;
   logic [6:0]        len_q;
   logic              abort_q, err_q, rdy_q;
   logic [WDOG_W-1:0] wdog_q;

   logic        tx_en, rx_en, wdog_to, intr, accept;
   logic        tx_pop, rx_push, tx_full, tx_empty, rx_full, rx_empty;
   logic [31:0] tx_head;
   logic [15:0] ctrl;
   logic        unused_mode;

   assign tx_en       = mode_q[6];
   assign rx_en       = mode_q[7];
   assign unused_mode = ^mode_q[1:0];
   assign wdog_to     = &wdog_q;
   assign intr        = sif.intr_tx | sif.intr_rx;
   assign accept      = (state_q == IDLE) & start_i;
   assign ctrl        = {rx_en, tx_en, mode_q[5], 1'b1, mode_q[4],
                         mode_q[3], mode_q[2], 1'b1, 1'b0, len_q};

   // tx_ready held low until the first clock after reset release
   assign sif.tx_ready = rdy_q & ~tx_full;
   assign sif.rx_valid = ~rx_empty;
   assign busy_o       = (state_q != IDLE);
   assign err_o        = err_q;

   spi_xfer_seq_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (sif.tx_valid & sif.tx_ready),
      .data_i  (sif.tx_data),
      .pop_i   (tx_pop),
      .data_o  (tx_head),
      .full_o  (tx_full),
      .empty_o (tx_empty),
      .level_o (tx_level_o)
   );

   spi_xfer_seq_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (rx_push),
      .data_i  (sif.rdata),
      .pop_i   (sif.rx_ready),
      .data_o  (sif.rx_data),
      .full_o  (rx_full),
      .empty_o (rx_empty),
      .level_o (rx_level_o)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         rem_q   <= '0;
         div_q   <= '0;
         ss_q    <= '0;
         mode_q  <= '0;
         len_q   <= '0;
         abort_q <= 1'b0;
         err_q   <= 1'b0;
         rdy_q   <= 1'b0;
         wdog_q  <= '0;
      end else begin
         state_q <= state_d;
         rdy_q   <= 1'b1;
         if (accept) begin
            rem_q   <= nwords_i;
            div_q   <= divider_i;
            ss_q    <= ss_i;
            mode_q  <= mode_i;
            len_q   <= char_len_i;
            abort_q <= 1'b0;
            err_q   <= 1'b0;
         end else if (abort_i && state_q != IDLE) begin
            abort_q <= 1'b1;
         end
         if (state_q == RD_CAP) rem_q <= rem_q - 8'd1;
         if (state_q == WAIT_END && !intr && wdog_to) err_q <= 1'b1;
         wdog_q <= (state_q == WAIT_END) ? wdog_q + WDOG_W'(1) : '0;
      end
   end

   always_comb begin
      state_d   = state_q;
      sif.addr  = 8'h00;
      sif.we    = 1'b0;
      sif.re    = 1'b0;
      sif.be    = 4'h0;
      sif.wdata = 32'h0;
      tx_pop    = 1'b0;
      rx_push   = 1'b0;
      done_o    = 1'b0;
      unique case (state_q)
         IDLE: if (start_i) state_d = WR_DIV;
         WR_DIV: begin
            sif.addr  = 8'h14;
            sif.we    = 1'b1;
            sif.be    = 4'hF;
            sif.wdata = {16'h0, div_q};
            state_d   = WR_SS;
         end
         WR_SS: begin
            sif.addr  = 8'h18;
            sif.we    = 1'b1;
            sif.be    = 4'hF;
            sif.wdata = {28'h0, ss_q};
            state_d   = WAIT_TX;
         end
         WAIT_TX: begin
            if (abort_q) state_d = FIN;
            else if ((!tx_en || !tx_empty) && (!rx_en || !rx_full))
               state_d = WR_TX;
         end
         WR_TX: begin
            sif.addr  = 8'h00;
            sif.we    = 1'b1;
            sif.be    = 4'hF;
            sif.wdata = tx_en ? tx_head : 32'h0;
            tx_pop    = tx_en;
            state_d   = WR_GO;
         end
         WR_GO: begin
            sif.addr  = 8'h10;
            sif.we    = 1'b1;
            sif.be    = 4'hF;
            sif.wdata = {16'h0, ctrl};
            state_d   = WAIT_END;
         end
         WAIT_END: begin
            unique case (1'b1)
               intr:    state_d = RD_REQ;
               wdog_to: state_d = FIN;
               default: state_d = WAIT_END;
            endcase
         end
         RD_REQ: begin
            sif.addr = 8'h20;
            sif.re   = 1'b1;
            state_d  = RD_CAP;
         end
         RD_CAP: begin
            rx_push = rx_en;
            if (rem_q != 8'd1 && !abort_q && !abort_i) state_d = WAIT_TX;
            else state_d = FIN;
         end
         FIN: begin
            done_o  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
endmodule

// File: tb/tb_spi_xfer_seq.sv
// Directed bench for spi_xfer_seq: two instances (default and RX_DEPTH=2 /
// WDOG_W=4) each behind a small spi_core stand-in that loops TX back to RX.
module tb_spi_xfer_seq;
   logic clk_i = 1'b0;
   logic rst_ni = 1'b0;
   always #5 clk_i = ~clk_i;

   int checks = 0;
   int errors = 0;

   spi_xfer_seq_if a_if ();
   spi_xfer_seq_if b_if ();

   logic        a_start = 0, b_start = 0, a_abort = 0, b_abort = 0;
   logic [7:0]  nwords = 0;
   logic [15:0] div = 0;
   logic [3:0]  ss = 0;
   logic [7:0]  mode = 0;
   logic [6:0]  len = 0;
   logic        a_busy, a_done, a_err, b_busy, b_done, b_err;
   logic [3:0]  a_txl, a_rxl, b_txl;
   logic [1:0]  b_rxl;

   spi_xfer_seq u_a (
      .clk_i(clk_i), .rst_ni(rst_ni), .start_i(a_start), .abort_i(a_abort),
      .nwords_i(nwords), .divider_i(div), .ss_i(ss), .mode_i(mode),
      .char_len_i(len), .busy_o(a_busy), .done_o(a_done), .err_o(a_err),
      .tx_level_o(a_txl), .rx_level_o(a_rxl), .sif(a_if.master)
   );

   spi_xfer_seq #(.RX_DEPTH(2), .WDOG_W(4)) u_b (
      .clk_i(clk_i), .rst_ni(rst_ni), .start_i(b_start), .abort_i(b_abort),
      .nwords_i(nwords), .divider_i(div), .ss_i(ss), .mode_i(mode),
      .char_len_i(len), .busy_o(b_busy), .done_o(b_done), .err_o(b_err),
      .tx_level_o(b_txl), .rx_level_o(b_rxl), .sif(b_if.master)
   );

   // core stand-ins: intr three cycles after GO, RX register = last TX word
   logic [31:0] a_txreg = 0, b_txreg = 0;
   int          a_go = 0, b_go = 0, a_rds = 0, b_rds = 0;
   bit          a_en = 1, b_en = 1;
   logic [39:0] a_log[$];
   logic [39:0] b_log[$];

   always @(posedge clk_i) begin
      a_if.rdata   <= a_if.re ? a_txreg : 32'h0;
      a_if.intr_tx <= a_en && (a_go == 1);
      a_if.intr_rx <= 1'b0;
      if (a_go != 0) a_go <= a_go - 1;
      if (a_if.re) a_rds <= a_rds + 1;
      if (a_if.we) begin
         a_log.push_back({a_if.addr, a_if.wdata});
         if (a_if.addr == 8'h00) a_txreg <= a_if.wdata;
         if (a_if.addr == 8'h10 && a_if.wdata[8]) a_go <= 3;
      end
   end

   always @(posedge clk_i) begin
      b_if.rdata   <= b_if.re ? b_txreg : 32'h0;
      b_if.intr_tx <= b_en && (b_go == 1);
      b_if.intr_rx <= 1'b0;
      if (b_go != 0) b_go <= b_go - 1;
      if (b_if.re) b_rds <= b_rds + 1;
      if (b_if.we) begin
         b_log.push_back({b_if.addr, b_if.wdata});
         if (b_if.addr == 8'h00) b_txreg <= b_if.wdata;
         if (b_if.addr == 8'h10 && b_if.wdata[8]) b_go <= 3;
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk_i);
      #1;
   endtask

   function automatic int go_cnt(input bit b, input int from);
      int n = 0;
      int sz = b ? b_log.size() : a_log.size();
      for (int i = from; i < sz; i++) begin
         if ((b ? b_log[i][39:32] : a_log[i][39:32]) == 8'h10) n++;
      end
      return n;
   endfunction

   task automatic push(input bit b, input logic [31:0] w);
      int i;
      i = 0;
      if (b) begin b_if.tx_data = w; b_if.tx_valid = 1; end
      else begin a_if.tx_data = w; a_if.tx_valid = 1; end
      while (i < 200 && !(b ? b_if.tx_ready : a_if.tx_ready)) begin
         tick(1);
         i++;
      end
      if (i >= 200) begin
         checks++; errors++;
         $display("FAIL push_timeout got ready=0 want ready=1");
      end
      tick(1);
      a_if.tx_valid = 0;
      b_if.tx_valid = 0;
   endtask

   task automatic pop(input bit b, output logic [31:0] d);
      int i;
      i = 0;
      while (i < 200 && !(b ? b_if.rx_valid : a_if.rx_valid)) begin
         tick(1);
         i++;
      end
      if (i >= 200) begin
         checks++; errors++;
         $display("FAIL pop_timeout got valid=0 want valid=1");
      end
      d = b ? b_if.rx_data : a_if.rx_data;
      if (b) b_if.rx_ready = 1; else a_if.rx_ready = 1;
      tick(1);
      a_if.rx_ready = 0;
      b_if.rx_ready = 0;
   endtask

   task automatic start(input bit b);
      if (b) b_start = 1; else a_start = 1;
      tick(1);
      a_start = 0;
      b_start = 0;
   endtask

   task automatic wait_done(input bit b, input int bound, output int cyc);
      cyc = 0;
      while (cyc < bound && !(b ? b_done : a_done)) begin
         tick(1);
         cyc++;
      end
      if (cyc >= bound) begin
         checks++; errors++;
         $display("FAIL done_timeout got no done want done within %0d", bound);
      end
   endtask

   task automatic test_reset();
      tick(2);
      checks++;
      if (a_if.tx_ready !== 1'b0) begin
         errors++; $display("FAIL rst_tx_ready got %b want 0", a_if.tx_ready);
      end
      checks++;
      if (a_busy !== 1'b0 || a_done !== 1'b0 || a_err !== 1'b0) begin
         errors++; $display("FAIL rst_status got %b%b%b want 000", a_busy, a_done, a_err);
      end
      checks++;
      if (a_txl !== 4'd0 || a_rxl !== 4'd0 || a_if.rx_valid !== 1'b0) begin
         errors++; $display("FAIL rst_levels got %0d/%0d want 0/0", a_txl, a_rxl);
      end
      checks++;
      if (a_if.we !== 1'b0 || a_if.re !== 1'b0) begin
         errors++; $display("FAIL rst_bus got we=%b re=%b want 0/0", a_if.we, a_if.re);
      end
      rst_ni = 1'b1;
      tick(2);
      checks++;
      if (a_if.tx_ready !== 1'b1 || b_if.tx_ready !== 1'b1) begin
         errors++; $display("FAIL post_rst_ready got %b%b want 11", a_if.tx_ready, b_if.tx_ready);
      end
   endtask

   task automatic test_single();
      logic [39:0] exp [4];
      int idx, cyc;
      exp[0] = 40'h14_00000004;
      exp[1] = 40'h18_00000001;
      exp[2] = 40'h00_000000A5;
      exp[3] = 40'h10_00005108;
      div = 16'd4; ss = 4'd1; mode = 8'h40; len = 7'd8; nwords = 8'd1;
      idx = a_log.size();
      push(0, 32'hA5);
      start(0);
      wait_done(0, 100, cyc);
      checks++;
      if (a_log.size() - idx != 4) begin
         errors++; $display("FAIL single_nwrites got %0d want 4", a_log.size() - idx);
      end
      for (int i = 0; i < 4; i++) begin
         if (idx + i < a_log.size()) begin
            checks++;
            if (a_log[idx+i] !== exp[i]) begin
               errors++;
               $display("FAIL single_write%0d got %h want %h", i, a_log[idx+i], exp[i]);
            end
         end
      end
      tick(1);
      checks++;
      if (a_done !== 1'b0 || a_busy !== 1'b0) begin
         errors++; $display("FAIL single_done_pulse got done=%b busy=%b want 0/0", a_done, a_busy);
      end
      checks++;
      if (a_txl !== 4'd0 || a_rxl !== 4'd0) begin
         errors++; $display("FAIL single_levels got %0d/%0d want 0/0", a_txl, a_rxl);
      end
   endtask

   task automatic test_loopback();
      logic [31:0] w [3];
      logic [31:0] d;
      int cyc;
      w[0] = 32'h1111_1111; w[1] = 32'h2222_2222; w[2] = 32'h3333_3333;
      mode = 8'hC0; nwords = 8'd3;
      for (int i = 0; i < 3; i++) push(0, w[i]);
      start(0);
      wait_done(0, 200, cyc);
      checks++;
      if (a_rxl !== 4'd3) begin
         errors++; $display("FAIL loop_rx_level got %0d want 3", a_rxl);
      end
      for (int i = 0; i < 3; i++) begin
         pop(0, d);
         checks++;
         if (d !== w[i]) begin
            errors++; $display("FAIL loop_word%0d got %h want %h", i, d, w[i]);
         end
      end
   endtask

   task automatic test_tx_wait();
      int idx, cyc;
      mode = 8'h40; nwords = 8'd1;
      idx = a_log.size();
      start(0);
      tick(20);
      checks++;
      if (a_log.size() - idx != 2 || a_busy !== 1'b1 || a_if.we !== 1'b0) begin
         errors++;
         $display("FAIL txwait_stall got writes=%0d busy=%b want 2/1", a_log.size() - idx, a_busy);
      end
      push(0, 32'h5A);
      wait_done(0, 100, cyc);
      checks++;
      if (a_log.size() - idx != 4) begin
         errors++; $display("FAIL txwait_nwrites got %0d want 4", a_log.size() - idx);
      end
      else begin
         checks++;
         if (a_log[idx+2] !== 40'h00_0000005A) begin
            errors++; $display("FAIL txwait_txword got %h want 000000005a", a_log[idx+2]);
         end
      end
   endtask

   task automatic test_rx_stall();
      logic [31:0] d;
      int idx, cyc;
      mode = 8'hC0; nwords = 8'd4;
      b_if.rx_ready = 0;
      idx = b_log.size();
      for (int i = 0; i < 4; i++) push(1, 32'hB0 + i);
      start(1);
      tick(80);
      checks++;
      if (b_busy !== 1'b1 || b_rxl !== 2'd2 || go_cnt(1, idx) != 2) begin
         errors++;
         $display("FAIL stall_hold got busy=%b rxl=%0d go=%0d want 1/2/2", b_busy, b_rxl, go_cnt(1, idx));
      end
      pop(1, d);
      checks++;
      if (d !== 32'hB0) begin
         errors++; $display("FAIL stall_pop0 got %h want b0", d);
      end
      tick(40);
      checks++;
      if (go_cnt(1, idx) != 3 || b_rxl !== 2'd2) begin
         errors++; $display("FAIL stall_resume got go=%0d rxl=%0d want 3/2", go_cnt(1, idx), b_rxl);
      end
      pop(1, d);
      checks++;
      if (d !== 32'hB1) begin
         errors++; $display("FAIL stall_pop1 got %h want b1", d);
      end
      wait_done(1, 100, cyc);
      checks++;
      if (go_cnt(1, idx) != 4 || b_rxl !== 2'd2) begin
         errors++; $display("FAIL stall_end got go=%0d rxl=%0d want 4/2", go_cnt(1, idx), b_rxl);
      end
      for (int i = 2; i < 4; i++) begin
         pop(1, d);
         checks++;
         if (d !== 32'hB0 + i) begin
            errors++; $display("FAIL stall_pop%0d got %h want %h", i, d, 32'hB0 + i);
         end
      end
   endtask

   task automatic test_watchdog();
      int rds0, cyc;
      mode = 8'h40; nwords = 8'd1; len = 7'd8;
      b_en = 0;
      push(1, 32'hC3);
      rds0 = b_rds;
      start(1);
      wait_done(1, 100, cyc);
      checks++;
      if (cyc != 21) begin
         errors++; $display("FAIL wdog_latency got %0d want 21", cyc);
      end
      checks++;
      if (b_err !== 1'b1 || b_rds != rds0) begin
         errors++; $display("FAIL wdog_err got err=%b reads=%0d want 1/0", b_err, b_rds - rds0);
      end
      tick(3);
      checks++;
      if (b_err !== 1'b1 || b_busy !== 1'b0) begin
         errors++; $display("FAIL wdog_sticky got err=%b busy=%b want 1/0", b_err, b_busy);
      end
      b_en = 1;
      push(1, 32'h3C);
      start(1);
      checks++;
      if (b_err !== 1'b0) begin
         errors++; $display("FAIL wdog_clear got %b want 0", b_err);
      end
      wait_done(1, 100, cyc);
      checks++;
      if (b_err !== 1'b0 || b_rds != rds0 + 1) begin
         errors++; $display("FAIL wdog_next got err=%b reads=%0d want 0/1", b_err, b_rds - rds0);
      end
   endtask

   task automatic test_abort();
      logic [31:0] d;
      int idx, cyc, n;
      mode = 8'hC0; nwords = 8'd5;
      for (int i = 0; i < 5; i++) push(0, 32'hD0 + i);
      idx = a_log.size();
      start(0);
      n = 0;
      while (n < 200 && go_cnt(0, idx) < 2) begin
         tick(1);
         n++;
      end
      if (n >= 200) begin
         checks++; errors++; $display("FAIL abort_go2_timeout got %0d want 2", go_cnt(0, idx));
      end
      a_abort = 1;
      tick(1);
      a_abort = 0;
      wait_done(0, 100, cyc);
      checks++;
      if (go_cnt(0, idx) != 2 || a_txl !== 4'd3 || a_rxl !== 4'd2) begin
         errors++;
         $display("FAIL abort_counts got go=%0d txl=%0d rxl=%0d want 2/3/2", go_cnt(0, idx), a_txl, a_rxl);
      end
      for (int i = 0; i < 2; i++) begin
         pop(0, d);
         checks++;
         if (d !== 32'hD0 + i) begin
            errors++; $display("FAIL abort_pop%0d got %h want %h", i, d, 32'hD0 + i);
         end
      end
   endtask

   task automatic test_reset_mid();
      mode = 8'h40; nwords = 8'd3;
      start(0);
      tick(6);
      checks++;
      if (a_busy !== 1'b1) begin
         errors++; $display("FAIL midrst_busy_before got %b want 1", a_busy);
      end
      rst_ni = 1'b0;
      #1;
      checks++;
      if (a_busy !== 1'b0 || a_txl !== 4'd0 || a_rxl !== 4'd0 || a_if.we !== 1'b0) begin
         errors++;
         $display("FAIL midrst_state got busy=%b txl=%0d rxl=%0d want 0/0/0", a_busy, a_txl, a_rxl);
      end
      checks++;
      if (a_if.tx_ready !== 1'b0) begin
         errors++; $display("FAIL midrst_ready got %b want 0", a_if.tx_ready);
      end
      tick(1);
      rst_ni = 1'b1;
      tick(2);
      checks++;
      if (a_busy !== 1'b0 || a_if.tx_ready !== 1'b1) begin
         errors++; $display("FAIL midrst_after got busy=%b ready=%b want 0/1", a_busy, a_if.tx_ready);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout got running want finished");
      $fatal(1, "timeout");
   end

   initial begin
      a_if.tx_valid = 0; a_if.tx_data = 0; a_if.rx_ready = 0;
      b_if.tx_valid = 0; b_if.tx_data = 0; b_if.rx_ready = 0;
      test_reset();
      test_single();
      test_loopback();
      test_tx_wait();
      test_rx_stall();
      test_watchdog();
      test_abort();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
